// File: rtl/backstabber_txn_scheduler.sv
// Round-robin scheduler sharing one M00_AXI burst master between NUM_REQ requesters.
// Optional WAIT watchdog: define BACKSTABBER_SCHED_WATCHDOG_EN.
module backstabber_txn_scheduler #(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = 32,
    parameter int GAP_CYCLES     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                      ACLK,
    input  logic                      ARESET,
    input  logic [NUM_REQ-1:0]        REQ_VALID,
    input  logic [NUM_REQ-1:0]        REQ_WRITE,
    input  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR,
    output logic [NUM_REQ-1:0]        REQ_READY,
    output logic [NUM_REQ-1:0]        RSP_VALID,
    output logic                      RSP_ERR,
    output logic                      TXN_INIT,
    output logic                      TXN_WRITE,
    output logic [ADDR_W-1:0]         TXN_ADDR,
    input  logic                      TXN_DONE,
    input  logic                      TXN_ERROR,
    output logic [IDX_W-1:0]          GRANT_ID,
    output logic                      BUSY,
    output logic                      TIMEOUT
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP,
        GAP
    } state_t;

    state_t             state;
    state_t             state_n;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   win_n;
    logic               win_found;
    logic               done_q;
    logic               done_edge;
    logic               done_hit;
    logic               edge_pend;
    logic               err_q;
    logic [3:0]         gap_cnt;
    logic               wd_exp;

`ifdef BACKSTABBER_SCHED_WATCHDOG_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    logic [WD_W-1:0] wd_cnt;
`endif

    function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [NUM_REQ-1:0] v;
        v = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // First requester at or after ptr+1, wrapping modulo NUM_REQ.
    always_comb begin
        win_n     = '0;
        win_found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            int j;
            j = (int'(ptr) + k) % NUM_REQ;
            if (!win_found && REQ_VALID[j]) begin
                win_found = 1'b1;
                win_n     = IDX_W'(j);
            end
        end
    end

    assign done_edge = TXN_DONE & ~done_q;
    assign done_hit  = done_edge | edge_pend;

`ifdef BACKSTABBER_SCHED_WATCHDOG_EN
    assign wd_exp = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) && !done_hit;
`else
    assign wd_exp  = 1'b0;
    assign TIMEOUT = 1'b0;
`endif

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    if (win_found) state_n = LAUNCH;
            LAUNCH:  state_n = WAIT;
            WAIT:    if (done_hit || wd_exp) state_n = RESP;
            RESP:    state_n = (GAP_CYCLES == 0) ? IDLE : GAP;
            GAP:     if (gap_cnt == 4'd0) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ptr       <= IDX_W'(NUM_REQ - 1);
            done_q    <= 1'b0;
            edge_pend <= 1'b0;
            err_q     <= 1'b0;
            gap_cnt   <= '0;
            REQ_READY <= '0;
            RSP_VALID <= '0;
            RSP_ERR   <= 1'b0;
            TXN_INIT  <= 1'b0;
            TXN_WRITE <= 1'b0;
            TXN_ADDR  <= '0;
            GRANT_ID  <= '0;
            BUSY      <= 1'b0;
`ifdef BACKSTABBER_SCHED_WATCHDOG_EN
            wd_cnt    <= '0;
            TIMEOUT   <= 1'b0;
`endif
        end else begin
            done_q    <= TXN_DONE;
            BUSY      <= (state_n != IDLE);
            REQ_READY <= '0;
            RSP_VALID <= '0;
            TXN_INIT  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (win_found) begin
                        ptr       <= win_n;
                        GRANT_ID  <= win_n;
                        TXN_ADDR  <= REQ_ADDR[int'(win_n)*ADDR_W +: ADDR_W];
                        TXN_WRITE <= REQ_WRITE[win_n];
                        REQ_READY <= onehot(win_n);
                        TXN_INIT  <= 1'b1;
                        edge_pend <= 1'b0;
                    end
                end
                LAUNCH: begin
                    // A fast master may finish while the init pulse is still out.
                    if (done_edge) begin
                        edge_pend <= 1'b1;
                        err_q     <= TXN_ERROR;
                    end
`ifdef BACKSTABBER_SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (done_hit) begin
                        RSP_VALID <= onehot(GRANT_ID);
                        RSP_ERR   <= done_edge ? TXN_ERROR : err_q;
                        edge_pend <= 1'b0;
                    end else if (wd_exp) begin
                        RSP_VALID <= onehot(GRANT_ID);
                        RSP_ERR   <= 1'b1;
`ifdef BACKSTABBER_SCHED_WATCHDOG_EN
                        TIMEOUT   <= 1'b1;
`endif
                    end else begin
`ifdef BACKSTABBER_SCHED_WATCHDOG_EN
                        wd_cnt <= wd_cnt + 1'b1;
`endif
                    end
                end
                RESP: begin
                    gap_cnt <= 4'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
                end
                GAP: begin
                    if (gap_cnt != 4'd0) gap_cnt <= gap_cnt - 4'd1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
